// File: rtl/mul_share_arb.sv
// mul_share_arb: shares one pipelined mul/shift unit between two requesters.
// Arbitration is round-robin, and at most one operation issues per cycle.
// A LATENCY-deep {valid, owner} pipe follows each op so that its result
// returns to the owner's held result registers. A squash discards the
// owner's in-flight work.
//
// Handshake: reqN is held until gntN. gntN is combinational in the same cycle,
// and the op is accepted on that clock edge. The requester then drops reqN, or
// keeps it high for a new op. A requester that is busy is never granted, so
// each requester has at most one op outstanding.
module mul_share_arb #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] opA0,
  input  logic [WIDTH-1:0] opA1,
  input  logic [WIDTH-1:0] opB0,
  input  logic [WIDTH-1:0] opB1,
  input  logic [4:0]       sa0,
  input  logic [4:0]       sa1,
  input  logic             squash0,
  input  logic             squash1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy0,
  output logic             busy1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] hi0,
  output logic [WIDTH-1:0] lo0,
  output logic [WIDTH-1:0] sres0,
  output logic [WIDTH-1:0] hi1,
  output logic [WIDTH-1:0] lo1,
  output logic [WIDTH-1:0] sres1,
  output logic [WIDTH-1:0] u_opA,
  output logic [WIDTH-1:0] u_opB,
  output logic [4:0]       u_sa,
  output logic [2:0]       u_op,
  output logic             u_en,
  input  logic [WIDTH-1:0] u_hi,
  input  logic [WIDTH-1:0] u_lo,
  input  logic [WIDTH-1:0] u_sres
);

  logic               busy0_q, busy0_d, busy1_q, busy1_d;
  logic               done0_q, done1_q;
  logic               last_q, last_d;
  logic [LATENCY-1:0] pv_q, pv_d, po_q, po_d;
  logic [WIDTH-1:0]   hi0_q, lo0_q, sres0_q, hi1_q, lo1_q, sres1_q;
  logic               elig0, elig1, grant0, grant1, winner;
  logic               tail_kill, retire0, retire1;

  // Grants are suppressed while reset is held, so every output is 0 during reset.
  assign elig0 = req0 & ~busy0_q & ~squash0 & ~reset;
  assign elig1 = req1 & ~busy1_q & ~squash1 & ~reset;

  // Round-robin pick: under contention, the requester not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      grant0 = last_q;
      grant1 = ~last_q;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign winner = grant1;
  assign last_d = (grant0 | grant1) ? winner : last_q;

  // Issue mux: drive the winner's operands, or all zeros when nothing issues.
  always_comb begin
    u_en  = 1'b0;
    u_op  = '0;
    u_opA = '0;
    u_opB = '0;
    u_sa  = '0;
    if (grant0) begin
      u_en  = 1'b1;
      u_op  = op0;
      u_opA = opA0;
      u_opB = opB0;
      u_sa  = sa0;
    end else if (grant1) begin
      u_en  = 1'b1;
      u_op  = op1;
      u_opA = opA1;
      u_opB = opB1;
      u_sa  = sa1;
    end
  end

  // Tracking pipe advance: stage 0 takes the new issue, and squashed owners' entries drop.
  always_comb begin
    pv_d    = '0;
    po_d    = '0;
    pv_d[0] = grant0 | grant1;
    po_d[0] = winner;
    for (int k = 1; k < LATENCY; k++) begin
      pv_d[k] = pv_q[k-1] & ~(po_q[k-1] ? squash1 : squash0);
      po_d[k] = po_q[k-1];
    end
  end

  // The tail retires unless its owner is squashed this cycle; squash wins.
  assign tail_kill = po_q[LATENCY-1] ? squash1 : squash0;
  assign retire0   = pv_q[LATENCY-1] & ~po_q[LATENCY-1] & ~tail_kill;
  assign retire1   = pv_q[LATENCY-1] &  po_q[LATENCY-1] & ~tail_kill;

  // Busy tracking: set on grant, clear on retire or squash.
  always_comb begin
    busy0_d = busy0_q;
    busy1_d = busy1_q;
    if (squash0)      busy0_d = 1'b0;
    else if (grant0)  busy0_d = 1'b1;
    else if (retire0) busy0_d = 1'b0;
    if (squash1)      busy1_d = 1'b0;
    else if (grant1)  busy1_d = 1'b1;
    else if (retire1) busy1_d = 1'b0;
  end

  // Control state: pointer, busy flags, done pulses and the tracking pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q  <= 1'b1;
      busy0_q <= 1'b0;
      busy1_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      pv_q    <= '0;
      po_q    <= '0;
    end else begin
      last_q  <= last_d;
      busy0_q <= busy0_d;
      busy1_q <= busy1_d;
      done0_q <= retire0;
      done1_q <= retire1;
      pv_q    <= pv_d;
      po_q    <= po_d;
    end
  end

  // Held result registers: capture the unit outputs on a retire for that owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi0_q   <= '0;
      lo0_q   <= '0;
      sres0_q <= '0;
      hi1_q   <= '0;
      lo1_q   <= '0;
      sres1_q <= '0;
    end else begin
      if (retire0) begin
        hi0_q   <= u_hi;
        lo0_q   <= u_lo;
        sres0_q <= u_sres;
      end
      if (retire1) begin
        hi1_q   <= u_hi;
        lo1_q   <= u_lo;
        sres1_q <= u_sres;
      end
    end
  end

  assign gnt0  = grant0;
  assign gnt1  = grant1;
  assign busy0 = busy0_q;
  assign busy1 = busy1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign hi0   = hi0_q;
  assign lo0   = lo0_q;
  assign sres0 = sres0_q;
  assign hi1   = hi1_q;
  assign lo1   = lo1_q;
  assign sres1 = sres1_q;

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one pipelined mul/shift unit between two requesters (two cores, or two issue ports of one core).
- Arbitrates requests round-robin and issues at most one operation per cycle to the shared unit.
- Tracks in-flight operations and their owners, and routes each result back to the owning requester's held result registers.
- Supports per-requester squash, so a flushed core's in-flight work is discarded.

Parameters:
- WIDTH, 32, data width of operands and results.
- LATENCY, 1, cycles from issue to valid hi/lo/shift_result at the shared unit output; legal range 1..4.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req0, req1  in  1 each  operation request, held until granted
- op0, op1  in  3 each  unit opcode: 4 MULTU, 6 MULT, 0 SLL, 1 SRL, 3 SRA
- opA0, opA1, opB0, opB1  in  WIDTH each  operands
- sa0, sa1  in  5 each  shift amount
- squash0, squash1  in  1 each  kill this requester's pending request and in-flight op
- gnt0, gnt1  out  1 each  combinational; request accepted this cycle
- busy0, busy1  out  1 each  registered; requester has an op in flight
- done0, done1  out  1 each  registered; one-cycle pulse, result regs updated
- hi0, lo0, sres0, hi1, lo1, sres1  out  WIDTH each  held results (hi, lo, shift_result)
- u_opA, u_opB  out  WIDTH each  to shared unit
- u_sa  out  5  to shared unit
- u_op  out  3  to shared unit
- u_en  out  1  to shared unit
- u_hi, u_lo, u_sres  in  WIDTH each  from shared unit

Behaviour:
- Reset (async): busy, done, hi, lo, sres all 0; in-flight pipe valids cleared; last-grant pointer = 1, so requester 0 wins the first contention.

Eligibility and grant:
- Requester i is eligible when req_i=1, busy_i=0 and squash_i=0.
- One eligible requester: it is granted.
- Both eligible: grant the requester not granted last; the pointer updates only on a grant.
- gnt_i is combinational, the same cycle as the request.
- The requester drops req the cycle after gnt, or keeps it high for a new op after its done.
- At most one op outstanding per requester.
- Requests while busy are held off (no grant) and are not an error.

Issue:
- On a grant, u_op/u_opA/u_opB/u_sa are muxed from the winner and u_en=1.
- With no grant, all u_* are driven 0 and u_en=0.
- u_* outputs are combinational from the request inputs.

Tracking:
- A LATENCY-deep shift register of {valid, owner}, advanced every cycle.
- Stage 0 is loaded with {grant, winner}.
- busy_i is set on grant_i and cleared when the tail entry for i retires or is squashed.

Retire:
- When the tail entry is valid with owner i and not squashed, on the next edge: hi_i<=u_hi, lo_i<=u_lo, sres_i<=u_sres, done_i<=1.
- Retire happens exactly LATENCY+1 edges after the grant edge.
- done_i deasserts the following cycle.
- hi/lo/sres are held until the next retire for that owner.

Squash:
- squash_i clears valid on every pipe entry owned by i in the same cycle.
- It clears busy_i at the next edge.
- It suppresses done_i and leaves hi_i/lo_i/sres_i unchanged.
- Squash of the other requester has no effect on i.

Simultaneous events:
- squash_i together with req_i: no grant, the other requester may be granted.
- Retire of i in the same cycle as a new request from i: no grant that cycle (busy still 1); grant on the next cycle at earliest.
- squash_i in the same cycle as the tail retire for i: squash wins, no done.

Throughput and result buffering:
- Back-to-back issues alternate between owners, one per cycle when both are eligible.
- The unit is never stalled; u_en is issue-valid only.
- The unit's shift-direction register samples at issue, so sres alignment needs no extra staging.

Test Plan:
- Reset then req0 MULT opA=-3 opB=7, LATENCY=1: gnt0 same cycle; done0 pulses 2 edges later; hi0=0xFFFFFFFF, lo0=0xFFFFFFEB; busy0 1→0.
- req0 and req1 both held (SLL sa=4 opB=1; SRL sa=4 opB=0x80) from reset: gnt0 first, gnt1 the next cycle; sres0=0x10, sres1=0x8; pointer then favours 0 again on the next contention.
- req0 kept high after grant, busy0=1: no second gnt0 until the cycle after done0; the second op retires correctly.
- Grant req1 MULTU 5×6, then squash1 one cycle later: no done1, lo1 keeps its previous value, busy1=0; req0 in flight concurrently still retires with the correct result.
- LATENCY=3, alternating grants every cycle for 8 ops: each done_i arrives exactly 4 edges after its gnt_i, with results matching the owner.
- Assert reset mid-flight with busy0=busy1=1: all outputs return to 0 immediately, no done after release, and the next req1-only request is granted.
